// File: rtl/inv_mixcolumns_seq.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// inv_mixcolumns_seq : sequential AES InvMixColumns; MIXCOL_FWD_EN adds mode.
// Revision: 1.0
//////////////////////////////////////////////////////////////////////////////
module inv_mixcolumns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in,
`ifdef MIXCOL_FWD_EN
   input  logic         mode,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out,
   output logic         busy
);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
         $fatal(1, "inv_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_BASE = 2'(4 - COLS_PER_CYCLE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   logic [127:0] work;
   logic [1:0]   cnt;
   logic         mode_q;
   logic [127:0] next_work;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col, input logic fwd);
      logic [7:0]  a  [4];
      logic [7:0]  x2 [4];
      logic [7:0]  x4 [4];
      logic [7:0]  x8 [4];
      logic [7:0]  m9 [4];
      logic [7:0]  mb [4];
      logic [7:0]  md [4];
      logic [7:0]  me [4];
      logic [31:0] res;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31 - 8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      // Row i uses the first matrix row rotated right by i byte positions.
      for (int i = 0; i < 4; i++) begin
         if (fwd)
            res[31 - 8*i -: 8] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
         else
            res[31 - 8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
      end
      return res;
   endfunction

   function automatic logic [127:0] step_cols(input logic [127:0] w, input logic [1:0] base,
                                              input logic fwd);
      logic [127:0] r;
      logic [1:0]   c;
      r = w;
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         c = base + 2'(j);
         r[127 - 32*int'(c) -: 32] = mix_column(w[127 - 32*int'(c) -: 32], fwd);
      end
      return r;
   endfunction

   always_comb begin
      next_work = step_cols(work, cnt, mode_q);
   end

   // out is a separate register so it survives the next capture into work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         work      <= '0;
         cnt       <= '0;
         mode_q    <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  work     <= in;
                  cnt      <= '0;
`ifdef MIXCOL_FWD_EN
                  mode_q   <= mode;
`else
                  mode_q   <= 1'b0;
`endif
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               work <= next_work;
               cnt  <= cnt + COL_STEP;
               if (cnt == LAST_BASE) begin
                  out       <= next_work;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/inv_mixcolumns_seq.md
Name: inv_mixcolumns_seq

Overview:
Sequential AES-128 InvMixColumns stage for the decryption datapath. It is the inverse of the forward column-mix used by the encryption round.
- Accepts one 128-bit state through a valid/ready handshake.
- Multiplies each 32-bit column by the inverse matrix {0E 0B 0D 09} over GF(2^8), computing COLS_PER_CYCLE columns per clock.
- Holds the result until the downstream stage takes it.
- Sits between AddRoundKey and InvShiftRows/InvSubBytes in an iterative decryption round.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 and 4; any other value is a fatal elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input state is presented.
- in_ready  output  1  block can accept a state.
- in  input  128  state; column c = in[127-32c -: 32], byte 0 of a column is its MSB.
- out_valid  output  1  result is held on out.
- out_ready  input  1  downstream accepts out.
- out  output  128  transformed state, same byte layout as in.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset: rst_n low asynchronously forces the following; any operation in flight is discarded with no partial output.
  - state = IDLE.
  - out = 128'h0, out_valid = 0, busy = 0, in_ready = 0 while rst_n is low.
  - Column counter = 0.
- First cycle after reset release: in_ready = 1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. If in_valid, capture in into the working register at the clock edge, clear the counter, go to BUSY. in is ignored when in_valid = 0.
  - BUSY: in_ready = 0. Each edge transforms columns counter .. counter+COLS_PER_CYCLE-1 in place and adds COLS_PER_CYCLE to the counter. After column 3 is written, go to DONE.
  - DONE: out_valid = 1. out equals the working register and is stable while out_valid && !out_ready. On an edge with out_ready = 1, go to IDLE and drop out_valid. out keeps its last value after the handshake.
- in_ready is 0 in DONE, even if out_ready is high. No accept in the same cycle as the output handshake.
- Latency: input handshake at edge N; out_valid is first high after edge N + 4/COLS_PER_CYCLE.
- Throughput: one state per 4/COLS_PER_CYCLE + 2 cycles when out_ready is held at 1.
- Per column (a0..a3 -> b0..b3), with ^ = XOR:
  - b0 = 0E*a0 ^ 0B*a1 ^ 0D*a2 ^ 09*a3
  - b1 = 09*a0 ^ 0E*a1 ^ 0B*a2 ^ 0D*a3
  - b2 = 0D*a0 ^ 09*a1 ^ 0E*a2 ^ 0B*a3
  - b3 = 0B*a0 ^ 0D*a1 ^ 09*a2 ^ 0E*a3
- GF(2^8) arithmetic:
  - Multiplication is modulo x^8+x^4+x^3+x+1 (0x11B).
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 8'h00).
  - 09 = x8^x1, 0B = x8^x2^x1, 0D = x8^x4^x1, 0E = x8^x4^x2, where x2 = xtime(a), x4 = xtime(x2), x8 = xtime(x4).
  - All values are 8 bits; no carries leave a byte.
- Column counter: 2 bits; it wraps to 0 on entry to DONE.
- Handshake protocol violations (in_valid dropped, out_ready glitching) never corrupt the held result.

Optional Feature:
- Macro: MIXCOL_FWD_EN.
- Defined:
  - Adds input port mode (1 bit), sampled together with in at the input handshake.
  - mode = 1 selects the forward matrix {02 03 01 01}: b0 = 02*a0 ^ 03*a1 ^ a2 ^ a3, rotating the same way for b1..b3.
  - mode = 0 selects the inverse matrix.
  - mode changes during BUSY have no effect.
- Undefined: the port is absent and the block is inverse-only.

Test Plan:
- Reset: assert rst_n = 0 mid-BUSY -> out = 0, out_valid = 0, busy = 0 immediately; in_ready = 1 the cycle after release.
- Known vector, COLS_PER_CYCLE = 1: in = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out = 128'hdb135345_f20a225c_01010101_c6c6c6c6, with out_valid first high 4 cycles after accept.
- Second vector: in = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff -> out = 128'hd4d4d4d5_2d26314c_00000000_ffffffff. Repeat for COLS_PER_CYCLE = 2 (latency 2) and 4 (latency 1).
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out and out_valid stable, in_ready = 0, and a new in_valid is not accepted until 1 cycle after out_ready = 1.
- Back-to-back: stream 8 random states with out_ready = 1 -> each output equals the software reference model; spacing is 6 cycles at COLS_PER_CYCLE = 1.
- MIXCOL_FWD_EN: mode = 1, in = 128'hdb135345_f20a225c_01010101_c6c6c6c6 -> out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6. Feeding that out back with mode = 0 returns the original input.
